// File: rtl/fault_threshold_det.sv
// Debounced window-comparator fault latch evaluated 4 cycles after each strobe rising edge.
// Optional saturating trip counter enabled by defining FAULT_DET_TRIPCNT_EN.
module fault_threshold_det #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                    lb_clk,
  input  logic                    reset,
  input  logic                    strobe,
  input  logic signed [15:0]      y,
  input  logic signed [15:0]      hi_lim,
  input  logic signed [15:0]      lo_lim,
  input  logic        [15:0]      hyst,
  input  logic        [CNT_W-1:0] deb_cnt,
  input  logic                    fault_clr,
  output logic                    fault_out,
  output logic                    fault_hi,
  output logic                    fault_lo,
  output logic        [1:0]       state,
  output logic        [15:0]      trip_cnt
);

  localparam int unsigned DLY_N = 4;
  localparam int unsigned BW    = 18;

  typedef enum logic [1:0] {
    ARMED   = 2'b00,
    PENDING = 2'b01,
    TRIPPED = 2'b10,
    RECOVER = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DLY_N-1:0]   dly_q, dly_d;
  logic               strobe_prev_q;
  logic               fault_out_q, fault_out_d;
  logic               fault_hi_q, fault_hi_d;
  logic               fault_lo_q, fault_lo_d;

  logic               edge_c, eval_c;
  logic               hi_c, lo_c, oor_c, in_band_c;
  logic               trip_entry_c, clear_c;
  logic [CNT_W-1:0]   deb_eff_c;
  logic [CNT_W:0]     cnt_nxt_c;
  logic signed [BW-1:0] y_ext_c, band_lo_c, band_hi_c;

  // Strobe edge detect and settle delay line
  always_comb begin
    edge_c = strobe & ~strobe_prev_q;
    dly_d  = {dly_q[DLY_N-2:0], edge_c};
    eval_c = dly_q[DLY_N-1];
  end

  // Trip and recovery comparisons; band edges widened so hysteresis never wraps
  always_comb begin
    hi_c      = (y > hi_lim);
    lo_c      = (y < lo_lim);
    oor_c     = hi_c | lo_c;
    y_ext_c   = {{2{y[15]}}, y};
    band_lo_c = {{2{lo_lim[15]}}, lo_lim} + {2'b00, hyst};
    band_hi_c = {{2{hi_lim[15]}}, hi_lim} - {2'b00, hyst};
    in_band_c = (y_ext_c >= band_lo_c) && (y_ext_c <= band_hi_c);
    deb_eff_c = (deb_cnt == '0) ? CNT_W'(1) : deb_cnt;
    cnt_nxt_c = {1'b0, cnt_q} + (CNT_W+1)'(1);
  end

  // State register
  always_ff @(posedge lb_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARMED;
      cnt_q         <= '0;
      dly_q         <= '0;
      strobe_prev_q <= 1'b1;
      fault_out_q   <= 1'b0;
      fault_hi_q    <= 1'b0;
      fault_lo_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dly_q         <= dly_d;
      strobe_prev_q <= strobe;
      fault_out_q   <= fault_out_d;
      fault_hi_q    <= fault_hi_d;
      fault_lo_q    <= fault_lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    trip_entry_c = 1'b0;
    clear_c      = 1'b0;
    case (state_q)
      ARMED: begin
        if (eval_c && oor_c) begin
          if (deb_eff_c <= CNT_W'(1)) begin
            state_d      = TRIPPED;
            trip_entry_c = 1'b1;
            cnt_d        = '0;
          end else begin
            state_d = PENDING;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PENDING: begin
        if (eval_c) begin
          if (!oor_c) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else if (cnt_nxt_c >= {1'b0, deb_eff_c}) begin
            state_d      = TRIPPED;
            trip_entry_c = 1'b1;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_nxt_c[CNT_W-1:0];
          end
        end
      end
      TRIPPED: begin
        if (eval_c && in_band_c) state_d = RECOVER;
      end
      RECOVER: begin
        // An out-of-range evaluation overrides a coincident clear
        if (eval_c && oor_c) begin
          state_d = TRIPPED;
        end else if (fault_clr) begin
          state_d = ARMED;
          clear_c = 1'b1;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  // Output logic
  always_comb begin
    fault_out_d = state_d[1];
    fault_hi_d  = fault_hi_q;
    fault_lo_d  = fault_lo_q;
    if (clear_c) begin
      fault_hi_d = 1'b0;
      fault_lo_d = 1'b0;
    end
    if (trip_entry_c) begin
      fault_hi_d = fault_hi_q | hi_c;
      fault_lo_d = fault_lo_q | (lo_c & ~hi_c);
    end
  end

  assign state     = state_q;
  assign fault_out = fault_out_q;
  assign fault_hi  = fault_hi_q;
  assign fault_lo  = fault_lo_q;

`ifdef FAULT_DET_TRIPCNT_EN
  logic [15:0] trip_cnt_q, trip_cnt_d;

  // Saturating count of fresh trips
  always_comb begin
    trip_cnt_d = trip_cnt_q;
    if (trip_entry_c && (trip_cnt_q != 16'hFFFF)) trip_cnt_d = trip_cnt_q + 16'd1;
  end

  always_ff @(posedge lb_clk or posedge reset) begin
    if (reset) trip_cnt_q <= '0;
    else       trip_cnt_q <= trip_cnt_d;
  end

  assign trip_cnt = trip_cnt_q;
`else
  assign trip_cnt = '0;
`endif

endmodule

// File: tb/tb_fault_threshold_det.sv
// Directed bench for fault_threshold_det: debounce, hysteresis recovery, clear, reset.
module tb_fault_threshold_det;

  localparam logic [1:0] ARMED   = 2'b00;
  localparam logic [1:0] PENDING = 2'b01;
  localparam logic [1:0] TRIPPED = 2'b10;
  localparam logic [1:0] RECOVER = 2'b11;

  logic               lb_clk = 1'b0;
  logic               reset;
  logic               strobe;
  logic signed [15:0] y;
  logic signed [15:0] hi_lim;
  logic signed [15:0] lo_lim;
  logic        [15:0] hyst;
  logic        [7:0]  deb_cnt;
  logic               fault_clr;
  logic               fault_out;
  logic               fault_hi;
  logic               fault_lo;
  logic        [1:0]  state;
  logic        [15:0] trip_cnt;

  int          errors = 0;
  int          checks = 0;
  int          exp_trips = 0;
  logic [1:0]  pre_state;

  fault_threshold_det #(.CNT_W(8)) dut (
    .lb_clk    (lb_clk),
    .reset     (reset),
    .strobe    (strobe),
    .y         (y),
    .hi_lim    (hi_lim),
    .lo_lim    (lo_lim),
    .hyst      (hyst),
    .deb_cnt   (deb_cnt),
    .fault_clr (fault_clr),
    .fault_out (fault_out),
    .fault_hi  (fault_hi),
    .fault_lo  (fault_lo),
    .state     (state),
    .trip_cnt  (trip_cnt)
  );

  always #5 lb_clk = ~lb_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_status(input string tag, input logic [1:0] st, input logic fo,
                            input logic fh, input logic fl);
    chk({tag, ".state"}, {14'd0, state}, {14'd0, st});
    chk({tag, ".fault_out"}, {15'd0, fault_out}, {15'd0, fo});
    chk({tag, ".fault_hi"}, {15'd0, fault_hi}, {15'd0, fh});
    chk({tag, ".fault_lo"}, {15'd0, fault_lo}, {15'd0, fl});
  endtask

  task automatic chk_trips(input string tag);
`ifdef FAULT_DET_TRIPCNT_EN
    chk(tag, trip_cnt, 16'(exp_trips));
`else
    chk(tag, trip_cnt, 16'd0);
`endif
  endtask

  // One strobe edge; evaluation lands on the 5th rising edge after strobe rises
  task automatic eval(input logic signed [15:0] yv, input logic clr);
    @(posedge lb_clk); #1;
    y      = yv;
    strobe = 1'b1;
    @(posedge lb_clk); #1;
    strobe = 1'b0;
    repeat (3) @(posedge lb_clk);
    #1;
    pre_state = state;
    fault_clr = clr;
    @(posedge lb_clk); #1;
    fault_clr = 1'b0;
    @(posedge lb_clk); #1;
  endtask

  task automatic clear_pulse();
    @(posedge lb_clk); #1;
    fault_clr = 1'b1;
    @(posedge lb_clk); #1;
    fault_clr = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    strobe    = 1'b1;
    y         = 16'sd2000;
    hi_lim    = 16'sd1000;
    lo_lim    = -16'sd1000;
    hyst      = 16'd0;
    deb_cnt   = 8'd0;
    fault_clr = 1'b0;
    repeat (3) @(posedge lb_clk);
    #1;
    chk_status("reset", ARMED, 1'b0, 1'b0, 1'b0);
    chk("reset.trip_cnt", trip_cnt, 16'd0);

    // Strobe held high across reset release: no evaluation
    reset = 1'b0;
    repeat (8) @(posedge lb_clk);
    #1;
    chk("strobe_high_release.state", {14'd0, state}, {14'd0, ARMED});
    strobe = 1'b0;

    // Exact limits are in range
    eval(16'sd1000, 1'b0);
    chk("at_hi_lim.state", {14'd0, state}, {14'd0, ARMED});
    eval(-16'sd1000, 1'b0);
    chk("at_lo_lim.state", {14'd0, state}, {14'd0, ARMED});

    // Three consecutive high samples trip with deb_cnt=3
    deb_cnt = 8'd3;
    eval(16'sd1200, 1'b0);
    chk("deb1.state", {14'd0, state}, {14'd0, PENDING});
    eval(16'sd1200, 1'b0);
    chk("deb2.state", {14'd0, state}, {14'd0, PENDING});
    eval(16'sd1200, 1'b0);
    exp_trips++;
    chk_status("trip_hi", TRIPPED, 1'b1, 1'b1, 1'b0);
    chk_trips("trip_hi.trip_cnt");

    // Hysteresis band is [-900, 900]
    hyst = 16'd100;
    eval(16'sd950, 1'b0);
    chk("hyst950.state", {14'd0, state}, {14'd0, TRIPPED});
    eval(16'sd901, 1'b0);
    chk("hyst901.state", {14'd0, state}, {14'd0, TRIPPED});
    eval(16'sd850, 1'b0);
    chk_status("recover850", RECOVER, 1'b1, 1'b1, 1'b0);
    clear_pulse();
    @(posedge lb_clk); #1;
    chk_status("cleared", ARMED, 1'b0, 1'b0, 1'b0);

    // In-range sample mid-debounce restarts the count
    eval(16'sd1200, 1'b0);
    eval(16'sd1200, 1'b0);
    eval(16'sd0, 1'b0);
    chk("debounce_abort.state", {14'd0, state}, {14'd0, ARMED});
    eval(16'sd1200, 1'b0);
    chk("restart1.state", {14'd0, state}, {14'd0, PENDING});
    eval(16'sd1200, 1'b0);
    chk("restart2.state", {14'd0, state}, {14'd0, PENDING});
    eval(16'sd1200, 1'b0);
    exp_trips++;
    chk("restart3.state", {14'd0, state}, {14'd0, TRIPPED});
    chk_trips("restart3.trip_cnt");
    eval(-16'sd900, 1'b0);
    chk("band_lo_edge.state", {14'd0, state}, {14'd0, RECOVER});

    // Clear coinciding with an out-of-range evaluation loses
    eval(-16'sd1500, 1'b1);
    chk_status("clr_vs_eval", TRIPPED, 1'b1, 1'b1, 1'b0);
    chk_trips("clr_vs_eval.trip_cnt");
    eval(16'sd0, 1'b0);
    clear_pulse();
    @(posedge lb_clk); #1;
    chk_status("cleared2", ARMED, 1'b0, 1'b0, 1'b0);

    // deb_cnt=0 trips on the first evaluation, exactly at the evaluation edge
    deb_cnt = 8'd0;
    eval(-16'sd1200, 1'b0);
    exp_trips++;
    chk("deb0.pre_state", {14'd0, pre_state}, {14'd0, ARMED});
    chk_status("deb0_trip_lo", TRIPPED, 1'b1, 1'b0, 1'b1);
    chk_trips("deb0.trip_cnt");

    // Clear ignored while TRIPPED; empty band never recovers
    clear_pulse();
    @(posedge lb_clk); #1;
    chk("clr_in_tripped.state", {14'd0, state}, {14'd0, TRIPPED});
    hyst = 16'd2000;
    eval(16'sd0, 1'b0);
    chk("empty_band.state", {14'd0, state}, {14'd0, TRIPPED});

    // Reset with an evaluation in flight discards it
    @(posedge lb_clk); #1;
    reset = 1'b1;
    @(posedge lb_clk); #1;
    reset = 1'b0;
    exp_trips = 0;
    hyst = 16'd100;
    chk_status("reset_tripped", ARMED, 1'b0, 1'b0, 1'b0);
    chk_trips("reset_tripped.trip_cnt");
    @(posedge lb_clk); #1;
    y      = -16'sd1200;
    strobe = 1'b1;
    @(posedge lb_clk); #1;
    strobe = 1'b0;
    @(posedge lb_clk); #1;
    reset = 1'b1;
    @(posedge lb_clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge lb_clk);
    #1;
    chk("inflight_dropped.state", {14'd0, state}, {14'd0, ARMED});

    // Reset during PENDING restarts the debounce from zero
    deb_cnt = 8'd3;
    eval(16'sd1200, 1'b0);
    chk("pend_before_reset.state", {14'd0, state}, {14'd0, PENDING});
    @(posedge lb_clk); #1;
    reset = 1'b1;
    @(posedge lb_clk); #1;
    reset = 1'b0;
    chk("pend_reset.state", {14'd0, state}, {14'd0, ARMED});
    eval(16'sd1200, 1'b0);
    eval(16'sd1200, 1'b0);
    chk("post_reset2.state", {14'd0, state}, {14'd0, PENDING});
    eval(16'sd1200, 1'b0);
    exp_trips++;
    chk_status("post_reset_trip", TRIPPED, 1'b1, 1'b1, 1'b0);
    chk_trips("post_reset_trip.trip_cnt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
